// File: rtl/paddle_pkg.sv
// paddle_pkg: shared FSM state type and default parameters for the paddle controllers.
`default_nettype none

package paddle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_AUTO   = 2'd3
  } paddle_state_t;

  localparam int DEF_POS_W        = 4;
  localparam int DEF_POS_MIN      = 1;
  localparam int DEF_POS_MAX      = 8;
  localparam int DEF_POS_RESET    = 4;
  localparam int DEF_REPEAT_DELAY = 8;
  localparam int DEF_REPEAT_RATE  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hold_repeat_timer.sv
// hold_repeat_timer: loadable down-counter with zero flag; load wins over decrement.
`default_nettype none

module hold_repeat_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: button-driven paddle position with hold delay and auto-repeat.
// Optional ball-tracking mode compiled in with PADDLE_AUTO_EN.
`default_nettype none

module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int POS_W        = DEF_POS_W,
  parameter int POS_MIN      = DEF_POS_MIN,
  parameter int POS_MAX      = DEF_POS_MAX,
  parameter int POS_RESET    = DEF_POS_RESET,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
`ifdef PADDLE_AUTO_EN
  input  logic             auto,
  input  logic [POS_W-1:0] ball_pos,
`endif
  output logic [POS_W-1:0] lutin,
  output logic             at_top,
  output logic             at_bottom,
  output logic             moving
);

  localparam int CW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CW-1:0]    DLY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]    RPT_LOAD = CW'(REPEAT_RATE - 1);
  localparam logic [POS_W-1:0] PMIN     = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] PMAX     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PRST     = POS_W'(POS_RESET);

  paddle_state_t    state, state_next;
  logic             dir_q, dir_next;      // 1 = up, 0 = down
  logic             req;
  logic             step_en, step_up;
  logic             ld, dec, cnt_zero;
  logic [CW-1:0]    ld_val;
  logic [POS_W-1:0] pos_next;

  assign req = up ^ down;

`ifdef PADDLE_AUTO_EN
  logic [POS_W-1:0] target;
  always_comb begin
    target = ball_pos;
    if (ball_pos < PMIN) target = PMIN;
    else if (ball_pos > PMAX) target = PMAX;
  end
`endif

  hold_repeat_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state;
    dir_next   = dir_q;
    step_en    = 1'b0;
    step_up    = 1'b0;
    ld         = 1'b0;
    ld_val     = DLY_LOAD;
    dec        = 1'b0;
`ifdef PADDLE_AUTO_EN
    if (auto) begin
      state_next = ST_AUTO;
      if ((state != ST_AUTO) || cnt_zero) begin
        ld      = 1'b1;
        ld_val  = RPT_LOAD;
        step_en = (target != lutin);
        step_up = (target > lutin);
      end else begin
        dec = 1'b1;
      end
    end else
`endif
    begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            step_en    = 1'b1;
            step_up    = up;
            dir_next   = up;
            ld         = 1'b1;
            state_next = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!req) begin
            state_next = ST_IDLE;
          end else if (up != dir_q) begin
            // reversal restarts the press sequence in the new direction
            step_en    = 1'b1;
            step_up    = up;
            dir_next   = up;
            ld         = 1'b1;
            state_next = ST_DELAY;
          end else if (cnt_zero) begin
            step_en    = 1'b1;
            step_up    = dir_q;
            ld         = 1'b1;
            ld_val     = RPT_LOAD;
            state_next = ST_REPEAT;
          end else begin
            dec = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pos_next = lutin;
    if (step_en) begin
      if (step_up) begin
        if (lutin < PMAX) pos_next = lutin + POS_W'(1);
      end else begin
        if (lutin > PMIN) pos_next = lutin - POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      lutin     <= PRST;
      at_top    <= (PRST == PMAX);
      at_bottom <= (PRST == PMIN);
      moving    <= 1'b0;
    end else begin
      state     <= state_next;
      dir_q     <= dir_next;
      lutin     <= pos_next;
      at_top    <= (pos_next == PMAX);
      at_bottom <= (pos_next == PMIN);
      moving    <= (pos_next != lutin);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: scoreboard bench; a hold-age reference model predicts every cycle.
`default_nettype none

module tb_paddle_ctrl;

  localparam int RD   = 8;
  localparam int RR   = 4;
  localparam int PMIN = 1;
  localparam int PMAX = 8;
  localparam int PRST = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       auto_sel = 1'b0;
  logic [3:0] ball = 4'd0;
  logic [3:0] lutin;
  logic       at_top, at_bottom, moving;

  paddle_ctrl #(
    .POS_W(4), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_RESET(PRST),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up        (up),
    .down      (down),
`ifdef PADDLE_AUTO_EN
    .auto      (auto_sel),
    .ball_pos  (ball),
`endif
    .lutin     (lutin),
    .at_top    (at_top),
    .at_bottom (at_bottom),
    .moving    (moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    bit top;
    bit bot;
    bit mov;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // model: m_dir 0 none, 1 up, 2 down, 3 auto; m_age counts edges since press/entry
  int m_pos = PRST;
  int m_dir = 0;
  int m_age = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_step(input int p, input bit go_up);
    if (go_up) return (p < PMAX) ? p + 1 : p;
    return (p > PMIN) ? p - 1 : p;
  endfunction

  function automatic exp_t model_edge(input bit u, input bit d, input bit r,
                                      input bit a, input int bp);
    exp_t e;
    int   old, nd, tgt;
    bit   st, sup;
    old = m_pos;
    st  = 1'b0;
    sup = 1'b0;
    if (r) begin
      m_pos = PRST; m_dir = 0; m_age = 0;
      e.pos = m_pos; e.top = (m_pos == PMAX); e.bot = (m_pos == PMIN); e.mov = 1'b0;
      return e;
    end
    if (a) begin
      tgt = (bp < PMIN) ? PMIN : (bp > PMAX) ? PMAX : bp;
      if (m_dir != 3) begin m_dir = 3; m_age = 0; end
      else m_age++;
      if ((m_age % RR) == 0 && tgt != m_pos) begin st = 1'b1; sup = (tgt > m_pos); end
    end else if (m_dir == 3) begin
      m_dir = 0;
    end else begin
      nd = (u ^ d) ? (u ? 1 : 2) : 0;
      if (nd == 0) begin
        m_dir = 0;
      end else if (nd != m_dir) begin
        m_dir = nd; m_age = 0; st = 1'b1; sup = (nd == 1);
      end else begin
        m_age++;
        if (m_age == RD || (m_age > RD && ((m_age - RD) % RR) == 0)) begin
          st = 1'b1; sup = (nd == 1);
        end
      end
    end
    if (st) m_pos = sat_step(m_pos, sup);
    e.pos = m_pos; e.top = (m_pos == PMAX); e.bot = (m_pos == PMIN); e.mov = (m_pos != old);
    return e;
  endfunction

  task automatic apply(input bit u, input bit d, input bit r, input bit a,
                       input int bp, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      up = u; down = d; reset = r; auto_sel = a; ball = 4'(bp);
      sb.push_back(model_edge(u, d, r, a, bp));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check_val("scoreboard_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("lutin", int'(lutin), e.pos);
        check_val("at_top", int'(at_top), int'(e.top));
        check_val("at_bottom", int'(at_bottom), int'(e.bot));
        check_val("moving", int'(moving), int'(e.mov));
      end
    end
  endtask

  initial begin
    // reset and long up-hold into the top stop
    apply(0, 0, 1, 0, 0, 2);
    check_val("reset_lutin", int'(lutin), 4);
    apply(1, 0, 0, 0, 0, 30);
    check_val("hold_up_lutin", int'(lutin), 8);
    check_val("hold_up_top", int'(at_top), 1);
    apply(0, 0, 0, 0, 0, 2);

    // run to the bottom stop, then a pulse that must not move
    apply(0, 1, 0, 0, 0, 40);
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 2);
    check_val("bottom_pulse_lutin", int'(lutin), 1);
    check_val("bottom_pulse_flag", int'(at_bottom), 1);

    // single pulses back to 4, then one down pulse
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 1);
    end
    apply(0, 1, 0, 0, 0, 1);
    check_val("pulse_down_lutin", int'(lutin), 3);
    check_val("pulse_down_moving", int'(moving), 1);
    apply(0, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 1);

    // both held, then release down with up still held
    apply(1, 1, 0, 0, 0, 20);
    apply(1, 0, 0, 0, 0, 14);
    apply(0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 1);
    end

    // reversal mid-hold
    apply(1, 0, 0, 0, 0, 10);
    apply(0, 1, 0, 0, 0, 12);
    apply(0, 0, 0, 0, 0, 2);

    // reset mid-hold discards repeat progress
    apply(1, 0, 0, 0, 0, 10);
    apply(1, 0, 1, 0, 0, 1);
    check_val("reset_midhold", int'(lutin), 4);
    apply(1, 0, 0, 0, 0, 10);
    apply(0, 0, 0, 0, 0, 2);

    // random held patterns
    for (int k = 0; k < 60; k++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 29) == 0), 0, 0, $urandom_range(1, 14));
    end

`ifdef PADDLE_AUTO_EN
    apply(0, 0, 1, 0, 0, 1);
    apply(0, 1, 0, 1, 15, 20);
    check_val("auto_hold_top", int'(lutin), 8);
    apply(1, 0, 0, 1, 0, 6);
    apply(1, 0, 1, 1, 0, 1);
    check_val("auto_reset", int'(lutin), 4);
    apply(0, 0, 0, 1, 6, 9);
    apply(1, 0, 0, 0, 6, 12);
    for (int k = 0; k < 30; k++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(1, 10));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle position controller for the Pong game datapath. It converts held up/down button levels into bounded paddle position steps with an initial step, a hold delay and a steady auto-repeat. An optional auto-tracking mode moves the paddle toward the ball row without user input. Its position output drives the paddle LED LUT exactly as the fixed-range player controller did, now with configurable range and repeat timing.

## Interface
Parameters:
- POS_W, 4, width of position output
- POS_MIN, 1, lowest legal position (inclusive)
- POS_MAX, 8, highest legal position (inclusive)
- POS_RESET, 4, position after reset; must satisfy POS_MIN ≤ POS_RESET ≤ POS_MAX
- REPEAT_DELAY, 8, cycles from first step to first repeat step (≥1)
- REPEAT_RATE, 4, cycles between repeat steps, also auto-mode step period (≥1)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- up  in  1  level, request position +1
- down  in  1  level, request position −1
- auto  in  1  auto-tracking select (present only with PADDLE_AUTO_EN)
- ball_pos  in  POS_W  target row for auto mode (present only with PADDLE_AUTO_EN)
- lutin  out  POS_W  registered paddle position, to LED LUT
- at_top  out  1  registered, lutin == POS_MAX
- at_bottom  out  1  registered, lutin == POS_MIN
- moving  out  1  registered, high for exactly the cycle after each edge where lutin changed

## Operation
- Effective request: dir = up XOR down. up&down both high counts as no request.
- FSM states: IDLE, DELAY, REPEAT, AUTO.
- IDLE: on an edge where a request is active, step once in that direction, load counter with REPEAT_DELAY−1 and go to DELAY.
- DELAY: while the same request holds, decrement. At 0, step, load REPEAT_RATE−1 and go to REPEAT.
- REPEAT: while the same request holds, decrement. At 0, step and reload REPEAT_RATE−1.
- In DELAY or REPEAT, request released (none or both) → IDLE with no step.
- Direction reversal in DELAY or REPEAT is treated as a new press: step immediately in the new direction, reload REPEAT_DELAY−1, go to DELAY.
- Step arithmetic is saturating. +1 at POS_MAX and −1 at POS_MIN leave lutin unchanged, do not assert moving, and keep the FSM timing running. There is no wrap-around.
- AUTO (macro only): entered from any state when auto=1. The target is ball_pos clamped to [POS_MIN, POS_MAX]. One step toward the target every REPEAT_RATE cycles, with the first step on the entry edge. Equal to target → hold. up/down are ignored. auto=0 → IDLE, and a held button then restarts as a fresh press on the next edge.
- Reset values: lutin=POS_RESET, FSM=IDLE, counter=0, moving=0. at_top and at_bottom equal the comparisons on POS_RESET.
- Reset has priority over all inputs. Reset mid-hold discards repeat progress.

## Timing
- A step decided at edge k is visible on lutin after edge k; latency is one edge from the sampled input.
- Held press starting at edge k: steps at edges k, k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_RATE, k+REPEAT_DELAY+2·REPEAT_RATE, …
- at_top and at_bottom are updated in the same edge as lutin.
- moving is high in the cycle following a changing edge.
- Counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).

## Configuration
- PADDLE_AUTO_EN defined: the auto and ball_pos ports and the AUTO state are compiled in.
- PADDLE_AUTO_EN undefined: those ports and the AUTO state are absent, and the block is a pure button controller with identical manual behaviour.

## Structure
- paddle_pkg holds the FSM state typedef (IDLE, DELAY, REPEAT, AUTO) and the default parameter constants. The computer-player block reuses it.
- Sub-module hold_repeat_timer: a loadable down-counter with a zero flag, parametrised on width. It is instantiated once.

## Test plan
- Reset: assert reset for 2 cycles → lutin=4, at_top=0, at_bottom=0, moving=0.
- Hold up 30 cycles from 4 → steps to 5, 6, 7, 8 at edges 0, 8, 12, 16; lutin stays at 8 from then on; at_top=1; moving never pulses after reaching 8.
- Single-cycle down pulse from 1 → lutin stays 1, at_bottom=1. Pulse down from 4 → lutin 3 after one edge, moving high one cycle.
- up and down held together for 20 cycles → lutin unchanged. Then release down with up held → step on that edge, then repeat per the DELAY timing.
- Hold up, reverse to down at cycle 10, hold 12 cycles → immediate −1 at the reversal edge, next −1 exactly 8 edges later.
- (PADDLE_AUTO_EN) auto=1, ball_pos=15, lutin=4 → steps every 4 cycles to 8 and holds. Reset asserted mid-sequence → lutin=4 on the next edge.
